// File: rtl/aibcr3pnr_rstgen_pkg.sv
// ---------------------------------------------------------------------------
// aibcr3pnr_rstgen_pkg
//   Shared definitions for the reset-pulse generator / release sequencer.
//   - Fixed 2-bit state encodings, kept as plain constants so the values stay
//     stable for anyone probing the state register by number.
//   - state_e: enum view of the same encodings, used for the FSM register.
//   - cnt_width(): width of the single shared sequence counter.
// ---------------------------------------------------------------------------
package aibcr3pnr_rstgen_pkg;

  localparam logic [1:0] ST_ASSERT   = 2'b00;
  localparam logic [1:0] ST_WAIT_LOW = 2'b01;
  localparam logic [1:0] ST_RELEASE  = 2'b10;
  localparam logic [1:0] ST_IDLE     = 2'b11;

  typedef enum logic [1:0] {
    S_ASSERT   = ST_ASSERT,
    S_WAIT_LOW = ST_WAIT_LOW,
    S_RELEASE  = ST_RELEASE,
    S_IDLE     = ST_IDLE
  } state_e;

  // One counter serves the assert window and both feedback waits, so it has
  // to hold the larger of the two terminal counts.
  function automatic int cnt_width(input int assert_cycles, input int timeout_cycles);
    int largest;
    largest = (assert_cycles > timeout_cycles) ? assert_cycles : timeout_cycles;
    return $clog2(largest);
  endfunction

endpackage

// File: rtl/aibcr3pnr_rstgen_if.sv
// ---------------------------------------------------------------------------
// aibcr3pnr_rstgen_if
//   Request/status bundle between a reset controller and one reset sequencer.
//   rst_req  : one-cycle request to start a reset sequence
//   busy     : sequence in progress
//   done     : one-cycle pulse, sequence completed normally
//   timeout  : sticky, last sequence timed out
//   master modport : the controller issuing requests
//   slave modport  : the sequencer (aibcr3pnr_rstgen)
// ---------------------------------------------------------------------------
interface aibcr3pnr_rstgen_if;

  logic rst_req;
  logic busy;
  logic done;
  logic timeout;

  modport master (
    output rst_req,
    input  busy,
    input  done,
    input  timeout
  );

  modport slave (
    input  rst_req,
    output busy,
    output done,
    output timeout
  );

endinterface

// File: rtl/aibcr3pnr_rstgen_bitsync.sv
// ---------------------------------------------------------------------------
// c3lib_sync3_ulvt_bitsync
//   Three-flop bit synchronizer, one independent chain per bit.
//   clk      : destination clock
//   rst      : synchronous active-high reset, loads RESET_VAL into all stages
//   data_in  : asynchronous input bits
//   data_out : synchronized bits, three clk edges after data_in settles
// ---------------------------------------------------------------------------
module c3lib_sync3_ulvt_bitsync #(
  parameter int                 DWIDTH    = 1,
  parameter logic [DWIDTH-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out
);

  genvar gi;
  generate
    for (gi = 0; gi < DWIDTH; gi++) begin : g_bit
      // stage_reg[0] is the metastability-catching flop; stage_reg[2] is the
      // only one downstream logic may look at.
      logic [2:0] stage_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          stage_reg <= {3{RESET_VAL[gi]}};
        end else begin
          stage_reg <= {stage_reg[1:0], data_in[gi]};
        end
      end

      assign data_out[gi] = stage_reg[2];
    end
  endgenerate

endmodule

// File: rtl/aibcr3pnr_rstgen.sv
// ---------------------------------------------------------------------------
// aibcr3pnr_rstgen
//   Driving end of an async-assert / sync-deassert reset path. On request (and
//   automatically after local reset) it holds rst_n_out low for at least
//   ASSERT_CYCLES cycles, waits until the remote synchronized reset (rst_n_fb)
//   is seen low, releases rst_n_out, waits until rst_n_fb is seen high again,
//   and reports done or a sticky timeout.
//
//   Parameters
//     ASSERT_CYCLES  : minimum cycles rst_n_out is held low (>= 2)
//     TIMEOUT_CYCLES : maximum cycles waited for each feedback edge (>= 4)
//   Ports
//     clk          : local clock
//     rst          : synchronous active-high reset
//     scan_mode_n  : 0 selects rst_n_bypass onto rst_n_out
//     rst_n_bypass : scan-mode reset value for rst_n_out
//     rst_n_fb     : remote synchronized reset, asynchronous to clk
//     rst_n_out    : active-low reset to the remote synchronizer
//     ctrl         : rst_req in; busy / done / timeout out (slave side)
// ---------------------------------------------------------------------------
module aibcr3pnr_rstgen
  import aibcr3pnr_rstgen_pkg::*;
#(
  parameter int ASSERT_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_mode_n,
  input  logic                  rst_n_bypass,
  input  logic                  rst_n_fb,
  output logic                  rst_n_out,
  aibcr3pnr_rstgen_if.slave     ctrl
);

  localparam int CNT_W = cnt_width(ASSERT_CYCLES, TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // -------------------------------------------------------------------------
  // Feedback synchronizer: the FSM only ever sees fb_sync, never raw rst_n_fb.
  // It resets to 0 so that after local reset the remote is presumed in reset.
  // -------------------------------------------------------------------------
  logic fb_sync;

  c3lib_sync3_ulvt_bitsync #(
    .DWIDTH    (1),
    .RESET_VAL (1'b0)
  ) u_fb_sync (
    .clk      (clk),
    .rst      (rst),
    .data_in  (rst_n_fb),
    .data_out (fb_sync)
  );

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e           state_reg,     state_next;
  logic [CNT_W-1:0] cnt_reg,       cnt_next;
  logic             rst_n_out_reg, rst_n_out_next;
  logic             busy_reg,      busy_next;
  logic             done_reg,      done_next;
  logic             timeout_reg,   timeout_next;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    done_next    = 1'b0;
    timeout_next = timeout_reg;

    case (state_reg)
      S_ASSERT: begin
        if (cnt_reg == ASSERT_LAST) begin
          state_next = S_WAIT_LOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      // The feedback test comes before the terminal-count test, so a
      // feedback edge arriving on the last allowed cycle is not a timeout.
      S_WAIT_LOW: begin
        if (!fb_sync) begin
          state_next = S_RELEASE;
          cnt_next   = '0;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          state_next   = S_IDLE;
          cnt_next     = '0;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_RELEASE: begin
        if (fb_sync) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          state_next   = S_IDLE;
          cnt_next     = '0;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      // Requests are only honoured here; anything arriving mid-sequence is
      // dropped rather than queued.
      S_IDLE: begin
        cnt_next = '0;
        if (ctrl.rst_req) begin
          state_next   = S_ASSERT;
          timeout_next = 1'b0;
        end
      end

      default: begin
        state_next = S_ASSERT;
        cnt_next   = '0;
      end
    endcase

    // Outputs are registered copies of what the next state implies, so
    // rst_n_out and busy change on the same edge as the state does. A
    // WAIT_LOW timeout lands in IDLE and therefore also releases rst_n_out.
    rst_n_out_next = (state_next == S_RELEASE) || (state_next == S_IDLE);
    busy_next      = (state_next != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_ASSERT;
      cnt_reg       <= '0;
      rst_n_out_reg <= 1'b0;
      busy_reg      <= 1'b1;
      done_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rst_n_out_reg <= rst_n_out_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      timeout_reg   <= timeout_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. The scan mux is the only combinational path to an output; the
  // FSM keeps sequencing underneath it.
  // -------------------------------------------------------------------------
  assign rst_n_out    = scan_mode_n ? rst_n_out_reg : rst_n_bypass;
  assign ctrl.busy    = busy_reg;
  assign ctrl.done    = done_reg;
  assign ctrl.timeout = timeout_reg;

endmodule

// File: tb/tb_aibcr3pnr_rstgen.sv
// ---------------------------------------------------------------------------
// tb_aibcr3pnr_rstgen
//   Bench for aibcr3pnr_rstgen with ASSERT_CYCLES=16, TIMEOUT_CYCLES=8.
//   rst_n_fb comes from a model remote synchronizer (async assert, 3-flop
//   release) or is forced stuck at 1 / 0.
// ---------------------------------------------------------------------------
module tb_aibcr3pnr_rstgen;

  localparam int ASSERT_CYCLES  = 16;
  localparam int TIMEOUT_CYCLES = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scan_mode_n = 1'b1;
  logic rst_n_bypass = 1'b0;
  logic rst_n_fb;
  logic rst_n_out;

  int vec_count  = 0;
  int miss_count = 0;

  // 0 = remote synchronizer model, 1 = stuck high, 2 = stuck low
  int fb_mode = 0;
  logic [2:0] remote_reg;

  aibcr3pnr_rstgen_if ctrl ();

  aibcr3pnr_rstgen #(
    .ASSERT_CYCLES  (ASSERT_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .scan_mode_n  (scan_mode_n),
    .rst_n_bypass (rst_n_bypass),
    .rst_n_fb     (rst_n_fb),
    .rst_n_out    (rst_n_out),
    .ctrl         (ctrl)
  );

  always #5 clk = ~clk;

  // Remote reset synchronizer: asserts asynchronously, releases after 3 edges.
  always @(posedge clk or negedge rst_n_out) begin
    if (!rst_n_out) remote_reg <= 3'b000;
    else            remote_reg <= {remote_reg[1:0], 1'b1};
  end

  assign rst_n_fb = (fb_mode == 0) ? remote_reg[2] : (fb_mode == 1);

  // Expected outcome of one reset sequence, measured from the trigger edge T
  // (the edge that accepts rst_req, or the last edge with rst high).
  typedef struct {
    string name;
    int    end_k;   // samples after T until busy is first seen low
    int    low;     // samples with rst_n_out low, T .. end
    int    dones;   // done pulses seen, T .. end
    int    tmo;     // timeout at end
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic scan_n;
    logic byp;
    logic exp_idle;   // registered rst_n_out is 1
    logic exp_asrt;   // registered rst_n_out is 0
  } scan_vec_t;

  scan_vec_t scan_tab[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic trigger_req();
    ctrl.rst_req = 1'b1;
    step();
    ctrl.rst_req = 1'b0;
  endtask

  // Runs from sample s_0 (just after the trigger edge) until busy falls,
  // optionally pulsing rst_req before the edges following samples pa / pb.
  task automatic measure(input int pa, input int pb);
    int   low   = 0;
    int   dones = 0;
    int   k     = 0;
    bit   ended = 0;
    exp_t e;
    while (!ended && k < 200) begin
      if (rst_n_out === 1'b0) low++;
      if (ctrl.done === 1'b1) dones++;
      if (ctrl.busy === 1'b0) begin
        ended = 1;
      end else begin
        ctrl.rst_req = (k == pa) || (k == pb);
        step();
        k++;
      end
    end
    ctrl.rst_req = 1'b0;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({e.name, "_end"},       k,            e.end_k);
      check({e.name, "_low"},       low,          e.low);
      check({e.name, "_dones"},     dones,        e.dones);
      check({e.name, "_timeout"},   ctrl.timeout, e.tmo);
      check({e.name, "_rst_n_out"}, rst_n_out,    1);
      step();
      check({e.name, "_done_clr"},  ctrl.done,    0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    int busy_seen;
    int k;

    // scan_n, bypass, expected with register=1 (IDLE), expected with register=0
    scan_tab[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    scan_tab[1] = '{1'b0, 1'b1, 1'b1, 1'b1};
    scan_tab[2] = '{1'b0, 1'b0, 1'b0, 1'b0};
    scan_tab[3] = '{1'b1, 1'b0, 1'b1, 1'b0};
    scan_tab[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    scan_tab[5] = '{1'b0, 1'b1, 1'b1, 1'b1};

    ctrl.rst_req = 1'b0;
    step(); step(); step();

    check("rst_rst_n_out", rst_n_out,    0);
    check("rst_busy",      ctrl.busy,    1);
    check("rst_done",      ctrl.done,    0);
    check("rst_timeout",   ctrl.timeout, 0);

    // Loopback: 16 ASSERT samples + 1 WAIT_LOW sample low; release after
    // edge 17, remote releases 3 edges later, local sync 3 more, done at 24.
    exp_q.push_back('{"poweron", 24, 17, 1, 0});
    rst = 1'b0;
    measure(-1, -1);

    // Requests during ASSERT (s_5) and RELEASE (s_20) are dropped.
    exp_q.push_back('{"ign_req", 24, 17, 1, 0});
    trigger_req();
    measure(5, 20);
    dones = 0;
    busy_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ctrl.done === 1'b1) dones++;
      if (ctrl.busy !== 1'b0) busy_seen++;
    end
    check("ign_req_extra_dones", dones,     0);
    check("ign_req_extra_busy",  busy_seen, 0);

    // Feedback stuck high: WAIT_LOW entered after edge 16, times out 8 later.
    fb_mode = 1;
    step(); step(); step(); step();
    exp_q.push_back('{"stuck1", 24, 24, 0, 1});
    trigger_req();
    measure(-1, -1);

    // Feedback stuck low: RELEASE entered after edge 17, times out 8 later.
    fb_mode = 2;
    step(); step(); step(); step();
    exp_q.push_back('{"stuck0", 25, 17, 0, 1});
    trigger_req();
    check("stuck0_timeout_cleared", ctrl.timeout, 0);
    measure(-1, -1);

    // Back to loopback: the accepted request clears the sticky timeout.
    fb_mode = 0;
    for (int i = 0; i < 6; i++) step();
    exp_q.push_back('{"recover", 24, 17, 1, 0});
    trigger_req();
    check("recover_timeout_cleared", ctrl.timeout, 0);
    measure(-1, -1);

    // Reset mid-RELEASE (s_19), then a full rerun from ASSERT.
    trigger_req();
    for (int i = 0; i < 19; i++) step();
    rst = 1'b1;
    step();
    check("midrst_rst_n_out", rst_n_out, 0);
    check("midrst_busy",      ctrl.busy, 1);
    check("midrst_done",      ctrl.done, 0);
    exp_q.push_back('{"rerun", 24, 17, 1, 0});
    rst = 1'b0;
    measure(-1, -1);

    // Scan mux while IDLE.
    for (int i = 0; i < 6; i++) begin
      scan_mode_n  = scan_tab[i].scan_n;
      rst_n_bypass = scan_tab[i].byp;
      #1;
      check($sformatf("scan_idle_%0d", i), rst_n_out, scan_tab[i].exp_idle);
    end
    scan_mode_n  = 1'b1;
    rst_n_bypass = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Scan mux while in ASSERT, all within one clock period.
    trigger_req();
    step(); step();
    for (int i = 0; i < 6; i++) begin
      scan_mode_n  = scan_tab[i].scan_n;
      rst_n_bypass = scan_tab[i].byp;
      #1;
      check($sformatf("scan_asrt_%0d", i), rst_n_out, scan_tab[i].exp_asrt);
    end
    check("scan_asrt_busy", ctrl.busy, 1);
    scan_mode_n  = 1'b1;
    rst_n_bypass = 1'b0;
    dones = 0;
    k = 0;
    while (ctrl.busy === 1'b1 && k < 60) begin
      step();
      k++;
      if (ctrl.done === 1'b1) dones++;
    end
    check("scan_seq_end",     k,            22);
    check("scan_seq_dones",   dones,        1);
    check("scan_seq_timeout", ctrl.timeout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
